// File: rtl/barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe
//
// Pipelined barrel shifter. The shift is split into CNT_W registered stages.
// Stage k moves the data by 2^k positions when bit k of the carried shift
// count is set, and passes it through unchanged otherwise. Each stage carries
// a valid bit, the data, the full shift count and the operation, so that
// every stage can act on its own copy. The whole pipeline advances together
// unless the result in the last stage is waiting for the consumer.
//
// Parameters
//   WIDTH  data width in bits (power of two, at least 4)
//   CNT_W  shift-count width, equal to log2(WIDTH); also the pipeline depth
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   an operation is presented on In/Cnt/Op
//   in_ready   the operation is accepted this cycle (equals the advance)
//   In         operand
//   Cnt        shift amount, 0 .. WIDTH-1
//   Op         00 ROL, 01 SLL, 10 SRA, 11 SRL
//   flush      invalidates every in-flight operation at the next edge
//   out_valid  Out holds a completed result
//   out_ready  the consumer takes Out this cycle
//   Out        result, driven straight from the last stage register
// ---------------------------------------------------------------------------
module barrel_shift_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } shiftOpE;

    // Stage registers
    logic [CNT_W-1:0]                  valid_q, valid_d;
    logic [CNT_W-1:0][WIDTH-1:0]       data_q,  data_d;
    logic [CNT_W-1:0][CNT_W-1:0]       cnt_q,   cnt_d;
    logic [CNT_W-1:0][1:0]             op_q,    op_d;

    // What each stage sees on its input side: the pipeline input for stage 0,
    // the previous stage's registers for the rest.
    logic [CNT_W-1:0]                  srcValid;
    logic [CNT_W-1:0][WIDTH-1:0]       srcData;
    logic [CNT_W-1:0][CNT_W-1:0]       srcCnt;
    logic [CNT_W-1:0][1:0]             srcOp;

    logic adv;

    // One fixed-distance step of the shifter. For SRA the current MSB is the
    // operand's original MSB, because every earlier SRA step replicated it.
    function automatic logic [WIDTH-1:0] stageShift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (shiftOpE'(op))
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_SLL:  r = d << amt;
            OP_SRA:  r = $unsigned($signed(d) >>> amt);
            default: r = d >> amt;
        endcase
        return r;
    endfunction

    // The pipeline only stalls when a finished result is not being taken.
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = valid_q[CNT_W-1];
    assign Out       = data_q[CNT_W-1];

    // Route the pipeline input and the stage outputs to the stage inputs.
    always_comb begin
        srcValid    = '0;
        srcData     = '0;
        srcCnt      = '0;
        srcOp       = '0;
        srcValid[0] = in_valid;
        srcData[0]  = In;
        srcCnt[0]   = Cnt;
        srcOp[0]    = Op;
        for (int k = 1; k < CNT_W; k++) begin
            srcValid[k] = valid_q[k-1];
            srcData[k]  = data_q[k-1];
            srcCnt[k]   = cnt_q[k-1];
            srcOp[k]    = op_q[k-1];
        end
    end

    // Next-state for every stage. Flush wins over everything for the valid
    // bits, so an input offered during a flush is dropped as well.
    always_comb begin
        valid_d = '0;
        data_d  = '0;
        cnt_d   = '0;
        op_d    = '0;
        for (int k = 0; k < CNT_W; k++) begin
            if (flush) begin
                valid_d[k] = 1'b0;
            end else if (adv) begin
                valid_d[k] = srcValid[k];
            end else begin
                valid_d[k] = valid_q[k];
            end
            data_d[k] = srcCnt[k][k] ? stageShift(srcData[k], srcOp[k], 1 << k)
                                     : srcData[k];
            cnt_d[k]  = srcCnt[k];
            op_d[k]   = srcOp[k];
        end
    end

    // Stage registers. Valid bits update every edge (so flush works while
    // stalled); the payload only moves when the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (adv) begin
                data_q <= data_d;
                cnt_q  <= cnt_d;
                op_q   <= op_d;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shift_pipe
//
// Self-checking bench for barrel_shift_pipe (WIDTH = 16, CNT_W = 4).
// Expected results come from refShift, which computes each operation
// directly with whole-word arithmetic, and from a queue of expected results
// for streaming traffic.
// ---------------------------------------------------------------------------
module tb_barrel_shift_pipe;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic [1:0]       Op;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;

    int checkCount;
    int passCount;

    logic [WIDTH-1:0] expQ[$];

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  o;
        logic [15:0] exp;
    } vecT;

    barrel_shift_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Cnt       (Cnt),
        .Op        (Op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-word reference: rotate via a doubled word, SRA via a sign-extended int.
    function automatic logic [15:0] refShift(input logic [15:0] a, input int c, input logic [1:0] o);
        logic [31:0] dbl;
        int          s;
        dbl = {a, a} << c;
        s   = int'($signed(a));
        s   = s >>> c;
        case (o)
            2'b00:   return dbl[31:16];
            2'b01:   return a << c;
            2'b10:   return s[15:0];
            default: return a >> c;
        endcase
    endfunction

    // Present one operation into an empty pipeline and count edges, starting
    // with the accept edge, until out_valid is seen. lat = -1 on timeout.
    task automatic sendAndWait(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                               output logic [15:0] res, output int lat);
        @(negedge clk);
        In        = a;
        Cnt       = c;
        Op        = o;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = Out;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        In        = '0;
        Cnt       = '0;
        Op        = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else passCount++;
        checkCount++;
        if (Out !== 16'h0000) $display("[TB] FAIL reset_out: got %h expected 0000", Out);
        else passCount++;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        vecT              vecs[6];
        logic [15:0]      res;
        int               lat;
        logic [15:0]      a;
        vecs[0] = '{16'h1234, 4'd4,  2'b00, 16'h2341};
        vecs[1] = '{16'h8001, 4'd1,  2'b00, 16'h0003};
        vecs[2] = '{16'h8001, 4'd1,  2'b01, 16'h0002};
        vecs[3] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF};
        vecs[4] = '{16'h4000, 4'd14, 2'b10, 16'h0001};
        vecs[5] = '{16'h8000, 4'd15, 2'b11, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            sendAndWait(vecs[i].a, vecs[i].c, vecs[i].o, res, lat);
            checkCount++;
            if (res !== vecs[i].exp)
                $display("[TB] FAIL directed_%0d_value: got %h expected %h", i, res, vecs[i].exp);
            else passCount++;
            checkCount++;
            if (lat !== 4) $display("[TB] FAIL directed_%0d_latency: got %0d expected 4", i, lat);
            else passCount++;
        end
        // Cnt = 0 returns the operand, and Cnt = 15 is legal, for every Op.
        for (int o = 0; o < 4; o++) begin
            a = 16'($urandom);
            sendAndWait(a, 4'd0, 2'(o), res, lat);
            checkCount++;
            if (res !== a) $display("[TB] FAIL cnt0_op%0d: got %h expected %h", o, res, a);
            else passCount++;
            a = 16'($urandom) | 16'h8000;
            sendAndWait(a, 4'd15, 2'(o), res, lat);
            checkCount++;
            if (res !== refShift(a, 15, 2'(o)))
                $display("[TB] FAIL cnt15_op%0d: got %h expected %h", o, res, refShift(a, 15, 2'(o)));
            else passCount++;
        end
    endtask

    task automatic test_back_to_back;
        int          sent;
        int          emitted;
        int          cyc;
        logic        expRdy;
        logic        prevStall;
        logic        sawStall;
        logic [15:0] lastOut;
        logic [15:0] exp;
        sent      = 0;
        emitted   = 0;
        cyc       = 0;
        prevStall = 1'b0;
        sawStall  = 1'b0;
        lastOut   = '0;
        expQ.delete();
        @(negedge clk);
        while (emitted < 8 && cyc < 40) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 8);
            In        = 16'($urandom);
            Cnt       = 4'($urandom);
            Op        = 2'($urandom);
            #1;
            expRdy = !(out_valid && !out_ready);
            checkCount++;
            if (in_ready !== expRdy) $display("[TB] FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, expRdy);
            else passCount++;
            if (out_valid && !out_ready) sawStall = 1'b1;
            if (prevStall) begin
                checkCount++;
                if (out_valid !== 1'b1 || Out !== lastOut)
                    $display("[TB] FAIL b2b_hold cyc %0d: got %b/%h expected 1/%h", cyc, out_valid, Out, lastOut);
                else passCount++;
            end
            if (out_valid && expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL b2b_spurious cyc %0d: got out_valid 1 expected 0", cyc);
            end else if (out_valid && out_ready) begin
                exp = expQ.pop_front();
                checkCount++;
                if (Out !== exp) $display("[TB] FAIL b2b_result_%0d: got %h expected %h", emitted, Out, exp);
                else passCount++;
                emitted++;
            end
            if (in_valid && expRdy) begin
                expQ.push_back(refShift(In, int'(Cnt), Op));
                sent++;
            end
            prevStall = out_valid && !out_ready;
            lastOut   = Out;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkCount++;
        if (emitted !== 8) $display("[TB] FAIL b2b_count: got %0d expected 8", emitted);
        else passCount++;
        checkCount++;
        if (sawStall !== 1'b1) $display("[TB] FAIL b2b_stall_seen: got %b expected 1", sawStall);
        else passCount++;
    endtask

    task automatic test_flush;
        logic        sawValid;
        logic [15:0] res;
        logic [15:0] a;
        int          lat;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            In       = 16'($urandom);
            Cnt      = 4'($urandom);
            Op       = 2'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        flush    = 1'b1;
        In       = 16'($urandom);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) sawValid = 1'b1;
            @(negedge clk);
        end
        checkCount++;
        if (sawValid !== 1'b0) $display("[TB] FAIL flush_no_output: got %b expected 0", sawValid);
        else passCount++;
        a = 16'($urandom);
        sendAndWait(a, 4'd7, 2'b00, res, lat);
        checkCount++;
        if (lat !== 4) $display("[TB] FAIL flush_next_latency: got %0d expected 4", lat);
        else passCount++;
        checkCount++;
        if (res !== refShift(a, 7, 2'b00)) $display("[TB] FAIL flush_next_value: got %h expected %h", res, refShift(a, 7, 2'b00));
        else passCount++;
    endtask

    task automatic test_async_reset;
        logic        sawValid;
        logic [15:0] res;
        logic [15:0] a;
        int          lat;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            In       = 16'($urandom);
            Cnt      = 4'($urandom);
            Op       = 2'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL areset_out_valid: got %b expected 0", out_valid);
        else passCount++;
        checkCount++;
        if (Out !== 16'h0000) $display("[TB] FAIL areset_out: got %h expected 0000", Out);
        else passCount++;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL areset_in_ready: got %b expected 1", in_ready);
        else passCount++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sawValid  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid !== 1'b0) $display("[TB] FAIL areset_lost_ops: got %b expected 0", sawValid);
        else passCount++;
        a = 16'($urandom);
        sendAndWait(a, 4'd3, 2'b10, res, lat);
        checkCount++;
        if (lat !== 4) $display("[TB] FAIL areset_next_latency: got %0d expected 4", lat);
        else passCount++;
        checkCount++;
        if (res !== refShift(a, 3, 2'b10)) $display("[TB] FAIL areset_next_value: got %h expected %h", res, refShift(a, 3, 2'b10));
        else passCount++;
    endtask

    task automatic test_random;
        int          accepted;
        int          cyc;
        logic        expRdy;
        logic        prevStall;
        logic [15:0] lastOut;
        logic [15:0] exp;
        accepted  = 0;
        cyc       = 0;
        prevStall = 1'b0;
        lastOut   = '0;
        expQ.delete();
        @(negedge clk);
        while ((accepted < 10000 || expQ.size() > 0) && cyc < 60000) begin
            flush     = (accepted < 10000) && ($urandom_range(0, 199) == 0);
            in_valid  = (accepted < 10000) && ($urandom_range(0, 9) < 8);
            out_ready = (accepted >= 10000) || ($urandom_range(0, 9) < 7);
            In        = 16'($urandom);
            Cnt       = 4'($urandom);
            Op        = 2'($urandom);
            #1;
            expRdy = !(out_valid && !out_ready);
            checkCount++;
            if (in_ready !== expRdy) $display("[TB] FAIL rnd_in_ready cyc %0d: got %b expected %b", cyc, in_ready, expRdy);
            else passCount++;
            if (prevStall) begin
                checkCount++;
                if (out_valid !== 1'b1 || Out !== lastOut)
                    $display("[TB] FAIL rnd_hold cyc %0d: got %b/%h expected 1/%h", cyc, out_valid, Out, lastOut);
                else passCount++;
            end
            if (out_valid && expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL rnd_spurious cyc %0d: got out_valid 1 expected 0", cyc);
            end else if (out_valid && out_ready) begin
                exp = expQ.pop_front();
                checkCount++;
                if (Out !== exp) $display("[TB] FAIL rnd_result cyc %0d: got %h expected %h", cyc, Out, exp);
                else passCount++;
            end
            if (flush) begin
                expQ.delete();
            end else if (in_valid && expRdy) begin
                expQ.push_back(refShift(In, int'(Cnt), Op));
                accepted++;
            end
            prevStall = out_valid && !out_ready && !flush;
            lastOut   = Out;
            @(negedge clk);
            cyc++;
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        checkCount++;
        if (expQ.size() != 0 || accepted != 10000)
            $display("[TB] FAIL rnd_complete: got %0d accepted/%0d pending expected 10000/0", accepted, expQ.size());
        else passCount++;
        repeat (6) @(negedge clk);
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL rnd_drained: got %b expected 0", out_valid);
        else passCount++;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
